traffic_signal_monitor: RTL

- Passive checker on the receiving end of the controller's lamp bus (red, yellow, green, pedestrian_walk, 4 bits each, one bit per approach: bit0 W, bit1 N, bit2 E, bit3 S).
- Each cycle it decodes the bus into direction and phase, locks onto the running cycle, and checks pattern legality, phase order, dwell times and emergency resume.
- Sits beside the controller in the intersection top level and feeds status and error logging.

---
 rtl/traffic_signal_monitor.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_signal_monitor.sv
// traffic_signal_monitor: passive checker on the receiving end of the lamp bus.
// Decodes every frame into (direction, phase), locks onto the running signal
// cycle and flags illegal lamp patterns, out-of-order phases, wrong dwell
// times and bad resumption after an emergency (all-yellow) interval.
module traffic_signal_monitor #(
  parameter int RED_CYCLES    = 10,
  parameter int YELLOW_CYCLES = 2,
  parameter int GREEN_CYCLES  = 10,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       red,
  input  logic [3:0]       yellow,
  input  logic [3:0]       green,
  input  logic [3:0]       pedestrian_walk,
  input  logic             err_clr,
  output logic             locked,
  output logic [1:0]       cur_dir,
  output logic [1:0]       cur_phase,
  output logic             emergency_active,
  output logic             err_pulse,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] PH_RED = 2'd0;
  localparam logic [1:0] PH_YEL = 2'd1;
  localparam logic [1:0] PH_GRN = 2'd2;

  localparam logic [2:0] E_MALFORMED = 3'd1;
  localparam logic [2:0] E_WALK      = 3'd2;
  localparam logic [2:0] E_SEQ       = 3'd3;
  localparam logic [2:0] E_SHORT     = 3'd4;
  localparam logic [2:0] E_LONG      = 3'd5;
  localparam logic [2:0] E_RESUME    = 3'd6;

  typedef enum logic [1:0] {ST_UNLOCKED, ST_SYNC, ST_TRACK, ST_EMERG} state_t;

  // Decoded view of one bus frame; bad_code is nonzero only for BAD frames.
  typedef struct packed {
    logic       norm;
    logic       emer;
    logic [1:0] dir;
    logic [1:0] phase;
    logic [2:0] bad_code;
  } frame_t;

  // Returns {valid, index} for a one-hot nibble.
  function automatic logic [2:0] onehot_idx(input logic [3:0] v);
    case (v)
      4'b0001: return 3'b100;
      4'b0010: return 3'b101;
      4'b0100: return 3'b110;
      4'b1000: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  state_t           state, nxt_state;
  logic [1:0]       dir, phase, nxt_dir, nxt_phase;
  logic [CNT_W-1:0] dwell, nxt_dwell, dwell_inc, exp_dwell;
  logic [1:0]       succ_dir, succ_phase;
  logic             err_hit;
  logic [2:0]       err_val;
  frame_t           fr;
  logic [2:0]       red_oh, yel_oh, grn_oh;

  assign red_oh = onehot_idx(~red);
  assign yel_oh = onehot_idx(yellow);
  assign grn_oh = onehot_idx(green);

  // Classify the current frame as EMER, NORM(d,p) or BAD(subcode).
  always_comb begin
    fr = '0;
    if (yellow == 4'hF && red == 4'h0 && green == 4'h0 && pedestrian_walk == 4'h0) begin
      fr.emer = 1'b1;
    end else if (red_oh[2] && yellow == 4'h0 && green == 4'h0 && pedestrian_walk == 4'h0) begin
      fr.norm  = 1'b1;
      fr.dir   = red_oh[1:0];
      fr.phase = PH_RED;
    end else if (red == 4'hF && yel_oh[2] && green == 4'h0 && pedestrian_walk == 4'h0) begin
      fr.norm  = 1'b1;
      fr.dir   = yel_oh[1:0];
      fr.phase = PH_YEL;
    end else if (red == 4'hF && yellow == 4'h0 && grn_oh[2]) begin
      // Walk lamp belongs to the approach opposite-indexed to the green one.
      if (pedestrian_walk == (4'b1000 >> grn_oh[1:0])) begin
        fr.norm  = 1'b1;
        fr.dir   = grn_oh[1:0];
        fr.phase = PH_GRN;
      end else begin
        fr.bad_code = E_WALK;
      end
    end else begin
      fr.bad_code = E_MALFORMED;
    end
  end

  // Successor phase and required dwell of the phase currently held.
  always_comb begin
    succ_dir   = (phase == PH_GRN) ? dir + 2'd1 : dir;
    succ_phase = PH_RED;
    exp_dwell  = CNT_W'(GREEN_CYCLES);
    case (phase)
      PH_RED: begin
        succ_phase = PH_YEL;
        exp_dwell  = CNT_W'(RED_CYCLES);
      end
      PH_YEL: begin
        succ_phase = PH_GRN;
        exp_dwell  = CNT_W'(YELLOW_CYCLES);
      end
      default: begin
        succ_phase = PH_RED;
        exp_dwell  = CNT_W'(GREEN_CYCLES);
      end
    endcase
    dwell_inc = (dwell == '1) ? dwell : dwell + 1'b1;
  end

  // Next-state / error decision for the lock tracker.
  always_comb begin
    nxt_state = state;
    nxt_dir   = dir;
    nxt_phase = phase;
    nxt_dwell = dwell;
    err_hit   = 1'b0;
    err_val   = 3'd0;
    case (state)
      ST_UNLOCKED: begin
        if (fr.norm) begin
          nxt_state = ST_SYNC;
          nxt_dir   = fr.dir;
          nxt_phase = fr.phase;
          nxt_dwell = CNT_W'(1);
        end
      end
      ST_SYNC, ST_TRACK: begin
        if (fr.emer) begin
          nxt_state = ST_EMERG;
        end else if (fr.norm) begin
          if (fr.dir == dir && fr.phase == phase) begin
            if (dwell == exp_dwell) begin
              err_hit = 1'b1;
              err_val = E_LONG;
            end else begin
              nxt_dwell = dwell_inc;
            end
          end else if (fr.dir == succ_dir && fr.phase == succ_phase) begin
            // Entry point of the first phase is unknown, so SYNC skips the check.
            if (state == ST_TRACK && dwell != exp_dwell) begin
              err_hit = 1'b1;
              err_val = E_SHORT;
            end else begin
              nxt_state = ST_TRACK;
              nxt_dir   = fr.dir;
              nxt_phase = fr.phase;
              nxt_dwell = CNT_W'(1);
            end
          end else begin
            err_hit = 1'b1;
            err_val = E_SEQ;
          end
        end else begin
          err_hit = 1'b1;
          err_val = fr.bad_code;
        end
      end
      ST_EMERG: begin
        if (fr.norm) begin
          // Controller restarts its phase timer on resume: full dwell required.
          if (fr.dir == dir && fr.phase == phase) begin
            nxt_state = ST_TRACK;
            nxt_dwell = CNT_W'(1);
          end else begin
            err_hit = 1'b1;
            err_val = E_RESUME;
          end
        end else if (!fr.emer) begin
          err_hit = 1'b1;
          err_val = E_MALFORMED;
        end
      end
    endcase
    if (err_hit) nxt_state = ST_UNLOCKED;
  end

  // State, registered status outputs and error log.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_UNLOCKED;
      dir              <= 2'd0;
      phase            <= 2'd0;
      dwell            <= '0;
      locked           <= 1'b0;
      emergency_active <= 1'b0;
      err_pulse        <= 1'b0;
      err_code         <= 3'd0;
      err_count        <= '0;
    end else begin
      state            <= nxt_state;
      dir              <= nxt_dir;
      phase            <= nxt_phase;
      dwell            <= nxt_dwell;
      locked           <= (nxt_state != ST_UNLOCKED);
      emergency_active <= fr.emer;
      err_pulse        <= err_hit;
      if (err_clr) begin
        err_code  <= 3'd0;
        err_count <= '0;
      end else if (err_hit) begin
        if (err_code == 3'd0) err_code <= err_val;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

  assign cur_dir   = dir;
  assign cur_phase = phase;

endmodule
